imem_resp: RTL

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_resp.sv
// Instruction memory with a one-cycle registered fetch port and a streaming program-load port.
// Optional build macro IMEM_PARITY_EN adds an even-parity bit per stored word and drives par_err.
module imem_resp #(
  parameter int          DEPTH  = 256,
  parameter logic [15:0] NOP_OP = 16'h0000,
  localparam int         AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   pc_in,
  output logic [15:0]   op_out,
  output logic          op_valid,
  output logic          stall,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic          load_last,
  input  logic [15:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          addr_err,
  output logic          par_err
);

`ifdef IMEM_PARITY_EN
  localparam int MW = 17;
`else
  localparam int MW = 16;
`endif

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {SERVE, LOAD, FLUSH} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [MW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW:0]     r_load_count;
  logic [15:0]     r_op;
  logic            r_op_valid;
  logic            r_addr_err;
  logic            r_par_err;

  logic            w_accept;
  logic            w_fetch;
  logic            w_in_range;
  logic [MW-1:0]   w_rd_word;
  logic            w_par_bad;
  logic [MW-1:0]   w_wr_word;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SERVE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    stall      = 1'b0;
    load_done  = 1'b0;
    case (r_state)
      SERVE: begin
        if (load_start) w_next = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        stall      = 1'b1;
        if (load_valid && load_last) w_next = FLUSH;
      end
      FLUSH: begin
        stall     = 1'b1;
        load_done = 1'b1;
        w_next    = SERVE;
      end
      default: w_next = SERVE;
    endcase
  end

  assign w_accept   = load_valid && (r_state == LOAD);
  // Fetch whenever the next cycle is a SERVE cycle, so the first op after FLUSH is already valid.
  assign w_fetch    = (w_next == SERVE);
  assign w_in_range = (pc_in[15:AW] == '0);
  assign w_rd_word  = r_mem[pc_in[AW-1:0]];

`ifdef IMEM_PARITY_EN
  assign w_wr_word  = {^load_data, load_data};
  assign w_par_bad  = ^w_rd_word;
`else
  assign w_wr_word  = load_data;
  assign w_par_bad  = 1'b0;
`endif

  // Storage has no reset so a program survives reset_n
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr       <= '0;
      r_load_count <= '0;
    end else if ((r_state == SERVE) && load_start) begin
      r_wptr       <= '0;
      r_load_count <= '0;
    end else if (w_accept) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_load_count != CNT_MAX) r_load_count <= r_load_count + 1'b1;
    end
  end

  // Registered fetch response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= NOP_OP;
      r_op_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_par_err <= 1'b0;
      if (!w_fetch) begin
        r_op       <= NOP_OP;
        r_op_valid <= 1'b0;
      end else if (!w_in_range) begin
        r_op       <= NOP_OP;
        r_op_valid <= 1'b0;
        r_addr_err <= 1'b1;
      end else if (w_par_bad) begin
        r_op       <= NOP_OP;
        r_op_valid <= 1'b0;
        r_par_err  <= 1'b1;
      end else begin
        r_op       <= w_rd_word[15:0];
        r_op_valid <= 1'b1;
      end
    end
  end

  assign op_out     = r_op;
  assign op_valid   = r_op_valid;
  assign load_count = r_load_count;
  assign addr_err   = r_addr_err;
  assign par_err    = r_par_err;

endmodule
